tt_um_chandrakanth_serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder_cell.sv | 42 ++++
 rtl/tt_um_chandrakanth_serial_adder.sv | 118 +++++++++++
 tb/tb_tt_um_chandrakanth_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and pin map for the bit-serial adder tile.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIDTH_MAX = 4;

  localparam int START_BIT = 0;
  localparam int BUSY_BIT  = 5;
  localparam int DONE_BIT  = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'hFC;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder assembled from two half-adder cells and an OR.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum_s;
  logic ha0_carry_s;
  logic ha1_carry_s;

  half_adder_cell u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (ha0_sum_s),
    .carry (ha0_carry_s)
  );

  half_adder_cell u_ha1 (
    .a     (ha0_sum_s),
    .b     (cin),
    .sum   (sum),
    .carry (ha1_carry_s)
  );

  assign cout = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/tt_um_chandrakanth_serial_adder.sv
// Bit-serial adder tile: captures A/B on a synchronized start edge and adds
// LSB-first through a carry register, one bit per enabled clock.
module tt_um_chandrakanth_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  state_t           state_r;
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [2:0]       cnt_r;
  logic [WIDTH:0]   result_r;
  logic             done_r;

  logic             start_edge_s;
  logic             busy_s;
  logic             sum_bit_s;
  logic             carry_next_s;
  logic [WIDTH-1:0] next_sum_s;
  logic [4:0]       res_ext_s;
  logic             unused_s;

  assign start_edge_s = s2_r & ~s3_r;
  assign busy_s       = (state_r == RUN);
  assign unused_s     = &{1'b0, uio_in[7:1]};

  full_adder_cell u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (sum_bit_s),
    .cout (carry_next_s)
  );

  // New sum bit enters at the MSB as the register shifts right.
  always_comb begin
    next_sum_s            = sum_sh_r >> 1'b1;
    next_sum_s[WIDTH-1]   = sum_bit_s;
  end

  // Synchronizer, control FSM and serial datapath; ena freezes everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      s3_r     <= 1'b0;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= 3'd0;
      result_r <= {(WIDTH+1){1'b0}};
      done_r   <= 1'b0;
    end else if (ena) begin
      s1_r <= uio_in[START_BIT];
      s2_r <= s1_r;
      s3_r <= s2_r;
      case (state_r)
        IDLE: begin
          if (start_edge_s) begin
            a_sh_r   <= ui_in[WIDTH-1:0];
            b_sh_r   <= ui_in[WIDTH+3:4];
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= 3'd0;
            done_r   <= 1'b0;
            state_r  <= RUN;
          end
        end
        RUN: begin
          carry_r  <= carry_next_s;
          sum_sh_r <= next_sum_s;
          a_sh_r   <= a_sh_r >> 1'b1;
          b_sh_r   <= b_sh_r >> 1'b1;
          cnt_r    <= cnt_r + 3'd1;
          if (cnt_r == 3'(WIDTH - 1)) begin
            result_r <= {carry_next_s, next_sum_s};
            done_r   <= 1'b1;
            state_r  <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Pin mapping; every bit below is a direct copy of a register.
  always_comb begin
    res_ext_s           = 5'b0;
    res_ext_s[WIDTH:0]  = result_r;
    uo_out              = 8'b0;
    uo_out[4:0]         = res_ext_s;
    uo_out[BUSY_BIT]    = busy_s;
    uo_out[DONE_BIT]    = done_r;
    uio_out             = 8'b0;
    uio_out[2]          = busy_s;
    uio_out[3]          = carry_r;
    uio_out[6:4]        = cnt_r;
    uio_oe              = UIO_OE_VAL;
  end

endmodule

// File: tb/tb_tt_um_chandrakanth_serial_adder.sv
// Self-checking bench for the bit-serial adder tile: vector table, corner
// sequences, exhaustive sweep and random operands against an arithmetic model.
module tb_tt_um_chandrakanth_serial_adder;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int checks = 0;
  int errors = 0;

  tt_um_chandrakanth_serial_adder #(.WIDTH(4)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ui;
    logic       chg;
    logic [4:0] exp_sum;
  } vec_t;

  function automatic logic [4:0] ref_sum(input logic [7:0] ui);
    int a;
    int b;
    a = int'(ui[3:0]);
    b = int'(ui[7:4]);
    return 5'(a + b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle and track the op; done must appear 7 edges later.
  task automatic start_and_check(input logic [7:0] ui, input logic chg, input logic [4:0] exp);
    int cyc;
    bit found;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    ui_in  = ui;
    uio_in = 8'h01;
    found  = 1'b0;
    cyc    = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1) uio_in = 8'h00;
      if (c == 3) begin
        check("busy_at_load", 32'(uo_out[5]), 32'd1);
        check("done_cleared", 32'(uo_out[6]), 32'd0);
      end
      if (c == 4 && chg) ui_in = 8'h00;
      if (c >= 4 && uo_out[6]) begin
        found = 1'b1;
        break;
      end
    end
    check("latency", found ? 32'(cyc) : 32'd99, 32'd7);
    check("result", 32'(uo_out[4:0]), 32'(exp));
    check("busy_after", 32'(uo_out[5]), 32'd0);
    check("uio_after", 32'(uio_out), 32'({1'b0, 3'd4, exp[4], 1'b0, 2'b00}));
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] snap_uio;
    logic [7:0] snap_uo;
    logic [7:0] r;
    int   rises;
    int   cyc;
    bit   found;
    logic prev_busy;

    vecs[0] = '{ui: 8'h53, chg: 1'b0, exp_sum: 5'd8};
    vecs[1] = '{ui: 8'hFF, chg: 1'b0, exp_sum: 5'd30};
    vecs[2] = '{ui: 8'hFF, chg: 1'b1, exp_sum: 5'd30};
    vecs[3] = '{ui: 8'h00, chg: 1'b0, exp_sum: 5'd0};
    vecs[4] = '{ui: 8'hF1, chg: 1'b0, exp_sum: 5'd16};
    vecs[5] = '{ui: 8'h12, chg: 1'b0, exp_sum: 5'd3};

    // Reset with noisy inputs
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_uo_out", 32'(uo_out), 32'd0);
    check("rst_uio_out", 32'(uio_out), 32'd0);
    check("rst_uio_oe", 32'(uio_oe), 32'hFC);
    uio_in = 8'h00;
    rst_n  = 1'b1;

    for (int i = 0; i < 6; i++)
      start_and_check(vecs[i].ui, vecs[i].chg, vecs[i].exp_sum);

    // Second start mid-RUN with new operands is ignored
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    ui_in  = 8'h12;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("ign_done", 32'(uo_out[6]), 32'd1);
    check("ign_result", 32'(uo_out[4:0]), 32'd3);
    repeat (6) @(negedge clk);
    check("ign_no_restart", 32'(uo_out[6:5]), 32'b10);
    check("ign_result_hold", 32'(uo_out[4:0]), 32'd3);
    start_and_check(8'h00, 1'b0, 5'd0);

    // Start held high yields exactly one operation
    ui_in     = 8'h77;
    uio_in    = 8'h01;
    rises     = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uo_out[5] && !prev_busy) rises++;
      prev_busy = uo_out[5];
    end
    check("held_one_op", 32'(rises), 32'd1);
    check("held_result", 32'(uo_out[6:0]), 32'({1'b1, 1'b0, 5'd14}));
    uio_in = 8'h00;

    // ena freeze mid-RUN delays completion by exactly the frozen cycles
    repeat (3) @(negedge clk);
    ui_in  = 8'h9A;
    uio_in = 8'h01;
    found  = 1'b0;
    cyc    = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1) uio_in = 8'h00;
      if (c == 4) begin
        snap_uio = uio_out;
        snap_uo  = uo_out;
        check("frz_cnt_before", 32'(uio_out[6:4]), 32'd1);
        ena = 1'b0;
      end
      if (c >= 5 && c <= 9) begin
        check("frz_uio", 32'(uio_out), 32'(snap_uio));
        check("frz_uo", 32'(uo_out), 32'(snap_uo));
      end
      if (c == 9) ena = 1'b1;
      if (c >= 4 && uo_out[6]) begin
        found = 1'b1;
        break;
      end
    end
    check("frz_latency", found ? 32'(cyc) : 32'd99, 32'd12);
    check("frz_result", 32'(uo_out[4:0]), 32'd19);

    // Reset at cnt==2 aborts the operation
    repeat (3) @(negedge clk);
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (4) @(negedge clk);
    check("abort_cnt", 32'(uio_out[6:4]), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_uo", 32'(uo_out), 32'd0);
    check("abort_uio", 32'(uio_out), 32'd0);
    rst_n = 1'b1;
    start_and_check(8'h35, 1'b0, 5'd8);

    // Exhaustive sweep, then random operands
    for (int v = 0; v < 256; v++) begin
      r = 8'(v);
      start_and_check(r, 1'b0, ref_sum(r));
    end
    for (int k = 0; k < 40; k++) begin
      r = 8'($urandom_range(0, 255));
      start_and_check(r, 1'($urandom_range(0, 1)), ref_sum(r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
